// File: rtl/program_fetch.sv
// Program fetch stage: walks a PC through a combinational program ROM and hands registered
// instructions to the decoder. Optional jmp predecode is enabled by FETCH_JMP_PREDECODE_EN.
module program_fetch #(
  parameter int ADDR_W   = 4,
  parameter int INSTR_W  = 16,
  parameter int RESET_PC = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               run,
  output logic [ADDR_W-1:0]  rom_addr,
  input  logic [INSTR_W-1:0] rom_data,
  output logic [INSTR_W-1:0] instr,
  output logic [ADDR_W-1:0]  instr_pc,
  output logic               instr_valid,
  input  logic               instr_ready,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_target,
  output logic [1:0]         state_dbg
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FETCH = 2'd1;
  localparam logic [1:0] HOLD  = 2'd2;

  logic [1:0]        state;
  logic [ADDR_W-1:0] pc;
  logic              active;
  logic              xfer;
  logic              capture;
  logic              is_jmp;
  logic [ADDR_W-1:0] jmp_target;

  // Decoder handshake: a word moves on an edge where instr_valid && instr_ready; once raised,
  // instr_valid and its payload stay put until that edge or a redirect/reset discards them.
  assign xfer    = instr_valid && instr_ready;
  assign active  = (state == FETCH) || (state == HOLD);
  assign capture = active && run && (!instr_valid || instr_ready);

`ifdef FETCH_JMP_PREDECODE_EN
  assign is_jmp     = (rom_data[INSTR_W-1 -: 4] == 4'b1000);
  assign jmp_target = ADDR_W'(rom_data[11:8]);
`else
  assign is_jmp     = 1'b0;
  assign jmp_target = pc;
`endif

  assign rom_addr  = pc;
  assign state_dbg = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      pc          <= ADDR_W'(RESET_PC);
      instr       <= '0;
      instr_pc    <= '0;
      instr_valid <= 1'b0;
    end else if (redirect_valid) begin
      // Redirect wins over everything, including a capture on the same edge.
      pc          <= redirect_target;
      instr_valid <= 1'b0;
      state       <= run ? FETCH : IDLE;
    end else if (capture) begin
      state <= FETCH;
      if (is_jmp) begin
        pc          <= jmp_target;
        instr_valid <= 1'b0;
      end else begin
        instr       <= rom_data;
        instr_pc    <= pc;
        instr_valid <= 1'b1;
        pc          <= pc + ADDR_W'(1);
      end
    end else begin
      if (xfer) instr_valid <= 1'b0;
      case (state)
        IDLE: if (run) state <= FETCH;
        FETCH, HOLD: begin
          if (instr_valid && !instr_ready) state <= HOLD;
          else if (!run)                   state <= IDLE;
          else                             state <= FETCH;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_program_fetch.sv
// Bench for program_fetch: directed scenarios with literal expectations, then randomized
// run/ready/redirect/reset traffic compared every cycle against a transaction-level model.
module tb_program_fetch;

`ifdef FETCH_JMP_PREDECODE_EN
  localparam bit PRE = 1'b1;
`else
  localparam bit PRE = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        run = 1'b0;
  logic [3:0]  rom_addr;
  logic [15:0] rom_data;
  logic [15:0] instr;
  logic [3:0]  instr_pc;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [3:0]  redirect_target = 4'd0;
  logic [1:0]  state_dbg;

  logic [15:0] rom [16];
  int          checks = 0;
  int          errors = 0;
  logic        cmp_en = 1'b0;
  logic [3:0]  exp_q [$];

  // clock/reset block
  always #5 clk = ~clk;

  program_fetch #(.ADDR_W(4), .INSTR_W(16), .RESET_PC(0)) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .rom_addr(rom_addr), .rom_data(rom_data),
    .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target), .state_dbg(state_dbg)
  );

  assign rom_data = rom[rom_addr];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: tracks the issued word, the next fetch address and whether the block is awake.
  logic [3:0]  m_pc = 4'd0;
  logic [15:0] m_instr = 16'd0;
  logic [3:0]  m_ipc = 4'd0;
  logic        m_valid = 1'b0;
  logic        m_awake = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    logic [15:0] word;
    logic        xfer;
    if (!rst_n) begin
      m_pc = 4'd0; m_instr = 16'd0; m_ipc = 4'd0; m_valid = 1'b0; m_awake = 1'b0;
    end else begin
      word = rom[m_pc];
      xfer = m_valid && instr_ready;
      if (redirect_valid) begin
        m_pc = redirect_target; m_valid = 1'b0; m_awake = run;
      end else if (m_awake && run && (!m_valid || instr_ready)) begin
        if (PRE && word[15:12] == 4'h8) begin
          m_pc = word[11:8]; m_valid = 1'b0;
        end else begin
          m_instr = word; m_ipc = m_pc; m_valid = 1'b1; m_pc = m_pc + 4'd1;
        end
      end else begin
        if (xfer) m_valid = 1'b0;
        if (run) m_awake = 1'b1;
        else if (!m_valid) m_awake = 1'b0;
      end
    end
  end

  // compare process
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("rom_addr", 32'(rom_addr), 32'(m_pc));
      chk("instr_valid", 32'(instr_valid), 32'(m_valid));
      if (m_valid) begin
        chk("instr", 32'(instr), 32'(m_instr));
        chk("instr_pc", 32'(instr_pc), 32'(m_ipc));
      end
      chk("idle", 32'(state_dbg == 2'd0), 32'(!m_awake));
    end
  end

  function automatic logic [15:0] safe_word();
    logic [15:0] w;
    w = 16'($urandom);
    if (w[15:12] == 4'h8) w[15] = 1'b0;
    return w;
  endfunction

  task automatic pulse_reset();
    #2 rst_n = 1'b0;
    #1 chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_addr", 32'(rom_addr), 32'd0);
    @(negedge clk);
    #2 rst_n = 1'b1;
  endtask

  initial begin
    int n;
    for (int i = 0; i < 16; i++) rom[i] = safe_word();
    #1 rst_n = 1'b0;
    #2;
    chk("reset_valid", 32'(instr_valid), 32'd0);
    chk("reset_instr", 32'(instr), 32'd0);
    chk("reset_instr_pc", 32'(instr_pc), 32'd0);
    chk("reset_rom_addr", 32'(rom_addr), 32'd0);
    chk("reset_state", 32'(state_dbg), 32'd0);
    cmp_en = 1'b1;

    // Sequential fetch with wrap 15 -> 0
    @(negedge clk);
    #2 rst_n = 1'b1;
    run = 1'b1; instr_ready = 1'b1;
    for (int k = 0; k < 18; k++) exp_q.push_back(4'(k));
    @(negedge clk);
    @(negedge clk);
    chk("seq_first_valid", 32'(instr_valid), 32'd1);
    chk("seq_pc", 32'(instr_pc), 32'(exp_q.pop_front()));
    while (exp_q.size() > 0) begin
      @(negedge clk);
      chk("seq_pc", 32'(instr_pc), 32'(exp_q.pop_front()));
    end

    // Stall at pc 2 for three cycles
    @(negedge clk);
    chk("stall_start_pc", 32'(instr_pc), 32'd2);
    instr_ready = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("stall_pc", 32'(instr_pc), 32'd2);
      chk("stall_instr", 32'(instr), 32'(rom[2]));
      chk("stall_valid", 32'(instr_valid), 32'd1);
    end
    instr_ready = 1'b1;
    @(negedge clk);
    chk("after_stall_pc", 32'(instr_pc), 32'd3);

    // Redirect during HOLD
    instr_ready = 1'b0;
    @(negedge clk);
    redirect_valid = 1'b1; redirect_target = 4'd10;
    @(negedge clk);
    chk("redir_bubble", 32'(instr_valid), 32'd0);
    redirect_valid = 1'b0; instr_ready = 1'b1;
    @(negedge clk);
    chk("redir_pc", 32'(instr_pc), 32'd10);
    chk("redir_valid", 32'(instr_valid), 32'd1);

    // Reset mid-stream at pc 7
    n = 0;
    while (instr_pc !== 4'd7 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("reach_pc7", 32'(instr_pc), 32'd7);
    pulse_reset();
    @(negedge clk);
    @(negedge clk);
    chk("restart_pc", 32'(instr_pc), 32'd0);
    chk("restart_valid", 32'(instr_valid), 32'd1);

    // Drop run while an instruction is stalled
    instr_ready = 1'b0;
    @(negedge clk);
    chk("drain_hold_pc", 32'(instr_pc), 32'd0);
    run = 1'b0;
    @(negedge clk);
    chk("drain_held_valid", 32'(instr_valid), 32'd1);
    chk("drain_held_pc", 32'(instr_pc), 32'd0);
    instr_ready = 1'b1;
    @(negedge clk);
    chk("drain_done_valid", 32'(instr_valid), 32'd0);
    chk("drain_idle", 32'(state_dbg), 32'd0);
    repeat (3) begin
      @(negedge clk);
      chk("idle_no_fetch", 32'(instr_valid), 32'd0);
      chk("idle_addr", 32'(rom_addr), 32'd1);
    end

    // jmp at pc 3 targeting pc 1
    rom[3] = 16'h8100;
    pulse_reset();
    run = 1'b1; instr_ready = 1'b1;
    repeat (4) @(negedge clk);
    chk("jmp_pre_pc", 32'(instr_pc), 32'd2);
    @(negedge clk);
`ifdef FETCH_JMP_PREDECODE_EN
    chk("jmp_bubble", 32'(instr_valid), 32'd0);
    @(negedge clk);
    chk("jmp_target_pc", 32'(instr_pc), 32'd1);
    chk("jmp_target_valid", 32'(instr_valid), 32'd1);
`else
    chk("jmp_issued_pc", 32'(instr_pc), 32'd3);
    chk("jmp_issued_word", 32'(instr), 32'h8100);
`endif

    // Randomized traffic
    for (int i = 0; i < 16; i++) begin
      rom[i] = 16'($urandom);
      if ($urandom_range(0, 3) == 0) rom[i][15:12] = 4'h8;
    end
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      run             = ($urandom_range(0, 9) != 0);
      instr_ready     = ($urandom_range(0, 9) < 7);
      redirect_valid  = ($urandom_range(0, 9) == 0);
      redirect_target = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 199) == 0) begin
        #2 rst_n = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b1;
      end
    end
    repeat (2) @(negedge clk);
    cmp_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/program_fetch.md
PROGRAM_FETCH -- requirements
Module: program_fetch

Interface
REQ-001 Parameter ADDR_W, default 4, SHALL set the program address width; the PC wraps at 2^ADDR_W.
REQ-002 Parameter INSTR_W, default 16, SHALL set the instruction width; opcode = bits [INSTR_W-1:INSTR_W-4].
REQ-003 Parameter RESET_PC, default 0, SHALL set the PC value loaded at reset.
REQ-004 Port clk, input, 1: sole clock; all state updates on the rising edge.
REQ-005 Port rst_n, input, 1: reset, asynchronous and active-low.
REQ-006 Port run, input, 1: fetch enable; low parks the block in IDLE.
REQ-007 Port rom_addr, output, ADDR_W: address to the program ROM; the ROM returns data combinationally in the same cycle.
REQ-008 Port rom_data, input, INSTR_W: instruction word returned by the ROM.
REQ-009 Port instr, output, INSTR_W: registered instruction handed to the decoder.
REQ-010 Port instr_pc, output, ADDR_W: address instr was fetched from.
REQ-011 Port instr_valid, output, 1: instr/instr_pc are valid.
REQ-012 Port instr_ready, input, 1: decoder accepts instr this cycle.
REQ-013 Port redirect_valid, input, 1: execute stage orders a PC change (taken br, or jmp when predecode is off).
REQ-014 Port redirect_target, input, ADDR_W: new PC on redirect.

Function
REQ-015 rom_addr SHALL equal the internal PC register combinationally, with no added latency.
REQ-016 States SHALL be IDLE, FETCH and HOLD.
- IDLE -> FETCH when run=1.
- FETCH -> HOLD when instr_valid=1 and instr_ready=0.
- HOLD -> FETCH when instr_ready=1.
- FETCH or HOLD -> IDLE when run=0 and no valid instruction is pending.
REQ-017 Capture condition: in FETCH, with instr_valid=0 or instr_ready=1, the block SHALL on the next edge load instr<=rom_data, instr_pc<=PC, instr_valid<=1 and PC<=PC+1 modulo 2^ADDR_W (15 -> 0 at default width).
REQ-018 In HOLD, instr, instr_pc, instr_valid and PC SHALL be held unchanged.
REQ-019 A transfer SHALL occur only when instr_valid=1 and instr_ready=1 on the same edge.
REQ-020 When instr_valid=1, instr_ready=0 and there is no redirect, instr_valid SHALL NOT drop.
REQ-021 Redirect SHALL have highest priority, in every state including HOLD. On an edge with redirect_valid=1:
- PC<=redirect_target;
- instr_valid<=0, discarding any pending instruction;
- state<=FETCH if run=1, else IDLE.
REQ-022 Redirect latency: redirect sampled at edge N SHALL give the target instruction with instr_valid=1 after edge N+1, provided run=1 and no stall.
REQ-023 Simultaneous redirect and capture SHALL resolve to the redirect; the ROM word fetched that cycle is dropped.
REQ-024 Dropping run while instr_valid=1 SHALL still allow that instruction to drain on handshake; no new capture SHALL occur while run=0.
REQ-025 Steady-state throughput SHALL be one instruction per cycle with instr_ready held high.

Reset
REQ-026 While rst_n=0, the block SHALL set PC=RESET_PC, instr=0 (nop), instr_pc=0, instr_valid=0 and state=IDLE, asynchronously.
REQ-027 Reset mid-operation SHALL discard any pending instruction; fetching SHALL resume at RESET_PC once rst_n=1 and run=1.

Configuration
REQ-028 Macro FETCH_JMP_PREDECODE_EN defined: a captured rom_data with opcode 4'b1000 (jmp) SHALL NOT be issued.
- It SHALL load PC<=rom_data[11:8] (low ADDR_W bits) and leave instr_valid=0 on that edge, costing one bubble cycle.
- The jump target instruction SHALL then be valid one edge later.
- redirect_valid SHALL still take priority over the predecoded jmp.
REQ-029 Macro FETCH_JMP_PREDECODE_EN undefined: a jmp SHALL be issued like any other instruction, and the PC SHALL change only through redirect.

Verification
REQ-030 Reset, then run=1 with instr_ready=1 -> instr_pc sequence 0,1,2,... one per cycle; after 15 it wraps to 0.
REQ-031 With instr_valid=1 at pc 2, hold instr_ready=0 for 3 cycles -> instr and instr_pc=2 stable throughout; then instr_ready=1 -> pc 3 follows next cycle.
REQ-032 redirect_valid=1, redirect_target=10, asserted during a HOLD -> pending instruction dropped; instr_valid=0 for one cycle; then instr_pc=10.
REQ-033 Predecode on, ROM[3]=16'b1000_0001_0000_0000 -> pc 3 never issued; one bubble; instr_pc=1 next. Predecode off -> pc 3 issued with the jmp word.
REQ-034 rst_n pulsed low mid-stream at pc 7 -> instr_valid=0 immediately; after release, fetch restarts at pc 0.
REQ-035 run dropped while instr_valid=1 and instr_ready=0 -> instruction held; it transfers on instr_ready=1; no further fetch; state IDLE.
